// File: rtl/pb_tile_pwr_seq.sv
// Tile power sequencer: walks each tile's clk_en/rst_n through a safe order,
// one tile at a time, with round-robin arbitration among pending tiles.
module pb_tile_pwr_seq #(
  parameter int unsigned NumTiles       = 16,
  parameter int unsigned ClkToRstCycles = 8,
  parameter int unsigned RstToClkCycles = 8,
  localparam int unsigned CntWidth =
    $clog2(((ClkToRstCycles > RstToClkCycles) ? ClkToRstCycles : RstToClkCycles) + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumTiles-1:0] tile_on_req_i,
  output logic [NumTiles-1:0] tile_rst_no,
  output logic [NumTiles-1:0] tile_clk_en_o,
  output logic [NumTiles-1:0] tile_on_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned IdxWidth = (NumTiles > 1) ? $clog2(NumTiles) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [IdxWidth-1:0]   r_grant, w_grant_nxt;
  logic [IdxWidth-1:0]   r_ptr, w_ptr_nxt;
  logic [CntWidth-1:0]   r_cnt, w_cnt_nxt;
  logic [NumTiles-1:0]   r_rst_n, w_rst_n_nxt;
  logic [NumTiles-1:0]   r_clk_en, w_clk_en_nxt;
  logic [NumTiles-1:0]   r_on, w_on_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;

  logic [NumTiles-1:0]   w_pending;
  logic                  w_found;
  logic [IdxWidth-1:0]   w_arb_idx;
  logic [IdxWidth:0]     w_cand;

  assign w_pending = tile_on_req_i ^ r_on;

  // Round-robin search: first pending tile at or after the pointer, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_arb_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < int'(NumTiles); k++) begin
      w_cand = {1'b0, r_ptr} + (IdxWidth+1)'(k);
      if (w_cand >= (IdxWidth+1)'(NumTiles)) begin
        w_cand = w_cand - (IdxWidth+1)'(NumTiles);
      end
      if (!w_found && w_pending[w_cand[IdxWidth-1:0]]) begin
        w_found   = 1'b1;
        w_arb_idx = w_cand[IdxWidth-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    w_rst_n_nxt  = r_rst_n;
    w_clk_en_nxt = r_clk_en;
    w_on_nxt     = r_on;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_arb_idx;
          w_ptr_nxt   = (w_arb_idx == IdxWidth'(NumTiles - 1)) ? '0 : w_arb_idx + 1'b1;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          if (tile_on_req_i[w_arb_idx]) begin
            w_state_nxt             = S_UP;
            w_clk_en_nxt[w_arb_idx] = 1'b1;
          end else begin
            w_state_nxt            = S_DOWN;
            w_rst_n_nxt[w_arb_idx] = 1'b0;
          end
        end
      end
      S_UP: begin
        if (r_cnt == CntWidth'(ClkToRstCycles - 1)) begin
          w_rst_n_nxt[r_grant] = 1'b1;
          w_on_nxt[r_grant]    = 1'b1;
          w_done_nxt           = 1'b1;
          w_busy_nxt           = 1'b0;
          w_state_nxt          = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DOWN: begin
        if (r_cnt == CntWidth'(RstToClkCycles - 1)) begin
          w_clk_en_nxt[r_grant] = 1'b0;
          w_on_nxt[r_grant]     = 1'b0;
          w_done_nxt            = 1'b1;
          w_busy_nxt            = 1'b0;
          w_state_nxt           = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant  <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_rst_n  <= '0;
      r_clk_en <= '0;
      r_on     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_grant  <= w_grant_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rst_n  <= w_rst_n_nxt;
      r_clk_en <= w_clk_en_nxt;
      r_on     <= w_on_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign tile_rst_no   = r_rst_n;
  assign tile_clk_en_o = r_clk_en;
  assign tile_on_o     = r_on;
  assign busy_o        = r_busy;
  assign done_o        = r_done;

endmodule

// File: tb/tb_pb_tile_pwr_seq.sv
// Bench for pb_tile_pwr_seq: directed scenarios with literal checks, plus a
// per-cycle comparison against a countdown-based behavioural model.
module tb_pb_tile_pwr_seq;

  localparam int N = 16;
  localparam int C = 8;
  localparam int R = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  tileOnReq;
  logic [N-1:0]  tileRstN;
  logic [N-1:0]  tileClkEn;
  logic [N-1:0]  tileOn;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  pb_tile_pwr_seq #(
    .NumTiles      (N),
    .ClkToRstCycles(C),
    .RstToClkCycles(R)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tile_on_req_i(tileOnReq),
    .tile_rst_no  (tileRstN),
    .tile_clk_en_o(tileClkEn),
    .tile_on_o    (tileOn),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: one job at a time; a job is a tile, a direction and a countdown
  // to its completion edge. Updated on the clock, read only on the falling edge.
  logic [N-1:0] mOn, mClk, mRst, mPend;
  logic         mBusy, mDone;
  bit           mActive, mUp;
  int           mLeft, mG, mPtr, mCand;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mOn = '0; mClk = '0; mRst = '0; mBusy = 0; mDone = 0;
      mActive = 0; mUp = 0; mLeft = 0; mG = 0; mPtr = 0;
    end else begin
      mDone = 1'b0;
      if (mActive) begin
        mLeft = mLeft - 1;
        if (mLeft == 0) begin
          if (mUp) begin mRst[mG] = 1'b1; mOn[mG] = 1'b1; end
          else     begin mClk[mG] = 1'b0; mOn[mG] = 1'b0; end
          mDone = 1'b1; mBusy = 1'b0; mActive = 0;
        end
      end else begin
        mPend = tileOnReq ^ mOn;
        if (mPend != '0) begin
          for (int k = 0; k < N; k++) begin
            mCand = (mPtr + k) % N;
            if (mPend[mCand]) begin mG = mCand; break; end
          end
          mPtr = (mG + 1) % N;
          mUp = tileOnReq[mG];
          mLeft = mUp ? C : R;
          mActive = 1; mBusy = 1'b1;
          if (mUp) mClk[mG] = 1'b1; else mRst[mG] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("model_rst_n", 32'(tileRstN), 32'(mRst));
    checkOutput("model_clk_en", 32'(tileClkEn), 32'(mClk));
    checkOutput("model_on", 32'(tileOn), 32'(mOn));
    checkOutput("model_busy", 32'(busy), 32'(mBusy));
    checkOutput("model_done", 32'(done), 32'(mDone));
    checkOutput("inv_rst_needs_clk", 32'(tileRstN & ~tileClkEn), 32'd0);
    checkOutput("inv_one_mid", 32'($countones(tileRstN ^ tileClkEn) <= 1), 32'd1);
  end

  task automatic applyStimulus(input logic [N-1:0] req);
    @(negedge clk);
    tileOnReq = req;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    tileOnReq = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    tileOnReq = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset with nothing requested.
    applyStimulus(16'h0000);
    repeat (20) @(negedge clk);
    checkOutput("idle_clk_en", 32'(tileClkEn), 32'h0);
    checkOutput("idle_rst_n", 32'(tileRstN), 32'h0);
    checkOutput("idle_busy", 32'(busy), 32'h0);

    // Power up tile 3.
    applyStimulus(16'h0008);
    @(negedge clk);
    checkOutput("up3_clk_en", 32'(tileClkEn), 32'h0008);
    checkOutput("up3_rst_n_low", 32'(tileRstN), 32'h0000);
    checkOutput("up3_busy", 32'(busy), 32'h1);
    repeat (7) @(negedge clk);
    checkOutput("up3_still_rst", 32'(tileRstN), 32'h0000);
    checkOutput("up3_busy_last", 32'(busy), 32'h1);
    @(negedge clk);
    checkOutput("up3_rst_n", 32'(tileRstN), 32'h0008);
    checkOutput("up3_done", 32'(done), 32'h1);
    checkOutput("up3_on", 32'(tileOn), 32'h0008);
    checkOutput("up3_busy_off", 32'(busy), 32'h0);
    @(negedge clk);
    checkOutput("up3_done_pulse", 32'(done), 32'h0);

    // Power tile 3 back down.
    applyStimulus(16'h0000);
    @(negedge clk);
    checkOutput("dn3_rst_n", 32'(tileRstN), 32'h0000);
    checkOutput("dn3_clk_kept", 32'(tileClkEn), 32'h0008);
    repeat (8) @(negedge clk);
    checkOutput("dn3_clk_en", 32'(tileClkEn), 32'h0000);
    checkOutput("dn3_on", 32'(tileOn), 32'h0000);
    checkOutput("dn3_done", 32'(done), 32'h1);

    // All tiles at once: strictly ordered, 9 cycles apart.
    doReset();
    applyStimulus(16'hFFFF);
    for (int k = 0; k < N; k++) begin
      repeat ((k == 0) ? 1 : 9) @(negedge clk);
      checkOutput($sformatf("all_clk_en_%0d", k), 32'(tileClkEn), (32'd1 << (k + 1)) - 32'd1);
      checkOutput($sformatf("all_rst_n_%0d", k), 32'(tileRstN), (32'd1 << k) - 32'd1);
    end
    repeat (8) @(negedge clk);
    checkOutput("all_on", 32'(tileOn), 32'h0000FFFF);
    checkOutput("all_rst_done", 32'(tileRstN), 32'h0000FFFF);

    // Pointer at 5 with tiles 2 and 7 pending: 7 wins, then wrap to 2.
    doReset();
    applyStimulus(16'h0010);
    repeat (9) @(negedge clk);
    checkOutput("ptr_t4_on", 32'(tileOn), 32'h0010);
    applyStimulus(16'h0094);
    @(negedge clk);
    checkOutput("ptr_first7", 32'(tileClkEn), 32'h0090);
    repeat (9) @(negedge clk);
    checkOutput("ptr_then2_clk", 32'(tileClkEn), 32'h0094);
    checkOutput("ptr_then2_rst", 32'(tileRstN), 32'h0090);

    // Request withdrawn mid-UP: finish UP, then run DOWN immediately.
    doReset();
    applyStimulus(16'h0001);
    repeat (5) @(negedge clk);
    tileOnReq = 16'h0000;
    repeat (4) @(negedge clk);
    checkOutput("tog_up_on", 32'(tileOn), 32'h0001);
    checkOutput("tog_up_rst_n", 32'(tileRstN), 32'h0001);
    checkOutput("tog_up_done", 32'(done), 32'h1);
    @(negedge clk);
    checkOutput("tog_dn_rst_n", 32'(tileRstN), 32'h0000);
    checkOutput("tog_dn_clk", 32'(tileClkEn), 32'h0001);
    checkOutput("tog_dn_busy", 32'(busy), 32'h1);
    repeat (8) @(negedge clk);
    checkOutput("tog_dn_clk_off", 32'(tileClkEn), 32'h0000);
    checkOutput("tog_dn_on", 32'(tileOn), 32'h0000);
    checkOutput("tog_dn_done", 32'(done), 32'h1);

    // Reset asserted mid-UP clears everything before the next clock edge.
    doReset();
    applyStimulus(16'h0020);
    repeat (3) @(negedge clk);
    checkOutput("abort_pre_clk", 32'(tileClkEn), 32'h0020);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_clk_en", 32'(tileClkEn), 32'h0);
    checkOutput("abort_rst_n", 32'(tileRstN), 32'h0);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_on", 32'(tileOn), 32'h0);
    @(negedge clk);
    tileOnReq = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pb_tile_pwr_seq.md
Name: pb_tile_pwr_seq

Overview:
- Sequences the clock-enable and reset outputs of the cluster and memory tiles. Replaces the direct register-to-pin wiring of the per-tile reset and clock-enable fields.
- Takes the per-tile desired power state from the SoC control register file. Drives each tile's clk_en/rst_n in a safe order.
- Serialises transitions through one shared sequencer using round-robin arbitration, which bounds simultaneous clock wake-up (inrush, IR drop).
- Sits in the Cheshire tile between the pb_soc_regs outputs and the tile-level clock-gating/reset ports.

Parameters:
- NumTiles, 16, number of controlled tiles; must be >= 1.
- ClkToRstCycles, 8, power-up: cycles the clock runs with reset still asserted before reset is released; must be >= 1.
- RstToClkCycles, 8, power-down: cycles reset is asserted with the clock still running before the clock is gated; must be >= 1.
- CntWidth, $clog2(max(ClkToRstCycles,RstToClkCycles)+1), internal counter width; derived, do not override.

Ports:
- clk_i  in  1  tile clock; single clock domain.
- rst_i  in  1  asynchronous reset, active-high.
- tile_on_req_i  in  NumTiles  desired state per tile (1=on), level, from register file.
- tile_rst_no  out  NumTiles  active-low reset to each tile.
- tile_clk_en_o  out  NumTiles  clock enable to each tile.
- tile_on_o  out  NumTiles  committed state per tile, for status readback.
- busy_o  out  1  sequencer is executing a transition.
- done_o  out  1  one-cycle pulse when a transition completes.

Behaviour:
- Reset (rst_i=1, async): tile_rst_no=0, tile_clk_en_o=0, tile_on_o=0, busy_o=0, done_o=0, counter=0, round-robin pointer=0, FSM=IDLE. Asserting rst_i mid-sequence aborts immediately to these values.
- All outputs are registered. There is no combinational path from tile_on_req_i to any output.
- pending[i] = tile_on_req_i[i] XOR tile_on_o[i].
- FSM states: IDLE, UP, DOWN.
- IDLE:
  - If pending != 0 in cycle T, grant the lowest-index pending tile at or after pointer, wrapping modulo NumTiles. Latch the granted index g.
  - Set pointer = (g+1) mod NumTiles.
  - Load counter = 0 and set busy_o=1 from T+1.
  - If tile_on_req_i[g]=1, go to UP: tile_clk_en_o[g] rises at T+1.
  - Otherwise go to DOWN: tile_rst_no[g] falls at T+1.
- UP:
  - The counter increments each cycle.
  - When counter == ClkToRstCycles-1, the next edge sets tile_rst_no[g]=1, tile_on_o[g]=1, done_o=1, busy_o=0, FSM=IDLE.
  - Result: tile_rst_no[g] rises exactly ClkToRstCycles cycles after tile_clk_en_o[g] rises.
- DOWN:
  - Symmetric to UP, using RstToClkCycles.
  - The final edge sets tile_clk_en_o[g]=0, tile_on_o[g]=0, done_o=1, busy_o=0, FSM=IDLE.
  - Result: tile_clk_en_o[g] falls exactly RstToClkCycles cycles after tile_rst_no[g] falls.
- Back-to-back transitions: arbitration may occur in the same cycle done_o is high. The next tile's first edge therefore follows one cycle after the previous tile's last edge. There is no dead cycle beyond that.
- Invariants for every tile at all times:
  - tile_rst_no[i]=1 implies tile_clk_en_o[i]=1; a tile never leaves reset without a clock.
  - At most one tile has clk_en and rst_n disagreeing, i.e. is mid-transition.
  - Non-granted tiles hold their outputs.
- Request changes during a sequence, including the granted tile's own request, are ignored until completion. After done, pending is re-evaluated, so a request toggled back is sequenced in the opposite direction later. A request toggled on and off again entirely while not granted produces no transition.
- done_o is a single-cycle pulse. busy_o is high from T+1 through the cycle before done_o.
- Fairness: any pending tile is granted within NumTiles-1 other transitions.

Test Plan:
- Reset release with tile_on_req_i=0 -> all outputs stay 0, busy_o=0 indefinitely.
- Defaults; tile_on_req_i[3]=1 at cycle 10 -> tile_clk_en_o[3]=1 at 11, tile_rst_no[3]=1 and done_o=1 at 19, tile_on_o[3]=1 at 19, busy_o high cycles 11-18.
- Tile 3 on; drop tile_on_req_i[3] at cycle 30 -> tile_rst_no[3]=0 at 31, tile_clk_en_o[3]=0 at 39.
- tile_on_req_i=16'hFFFF at once -> tiles power up in order 0,1,...,15; each clk_en rises 9 cycles after the previous one; no two tiles are mid-transition simultaneously. An assertion checks the rst_n implies clk_en invariant.
- Pointer at 5, pending {2,7} -> tile 7 granted first, then tile 2 (wrap).
- Power-up of tile 0 in progress; toggle tile_on_req_i[0] 1 to 0 at counter=4 -> tile 0 completes UP (tile_on_o[0]=1), then immediately runs DOWN. A second test drives rst_i high mid-UP -> all outputs 0 asynchronously in the same cycle.
